// File: rtl/victim_cache_ctrl.sv
// Tag/valid/dirty state, FIFO replacement and three-way arbitration for the L1.5 victim cache.
// A dirty victim slot is written back before the insert lands in the data array.
`timescale 1ns/1ps

module victim_cache_ctrl #(
  parameter int ADDR_WIDTH   = 36,
  parameter int NUM_ENTRIES  = 16,
  parameter int IDX_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_inv_val,
  input  logic [ADDR_WIDTH-1:0] i_inv_addr,
  output logic                  o_inv_rdy,
  output logic                  o_inv_resp_val,
  output logic                  o_inv_resp_hit,
  output logic                  o_inv_resp_dirty,
  output logic [IDX_WIDTH-1:0]  o_inv_resp_idx,
  input  logic                  i_ins_val,
  input  logic [ADDR_WIDTH-1:0] i_ins_addr,
  input  logic                  i_ins_dirty,
  output logic                  o_ins_rdy,
  input  logic                  i_lk_val,
  input  logic [ADDR_WIDTH-1:0] i_lk_addr,
  output logic                  o_lk_rdy,
  output logic                  o_lk_resp_val,
  output logic                  o_lk_resp_hit,
  output logic                  o_lk_resp_dirty,
  output logic [IDX_WIDTH-1:0]  o_lk_resp_idx,
  output logic                  o_wb_val,
  output logic [IDX_WIDTH-1:0]  o_wb_idx,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  input  logic                  i_wb_rdy,
  output logic                  o_arr_we,
  output logic [IDX_WIDTH-1:0]  o_arr_widx
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_INS_WR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [ADDR_WIDTH-1:0]  r_tag [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_dirty;
  logic [IDX_WIDTH-1:0]   r_ptr;
  logic [SW-1:0]          r_starve;

  logic [ADDR_WIDTH-1:0]  r_ins_addr;
  logic                   r_ins_dirty;
  logic                   r_ins_dup;
  logic [IDX_WIDTH-1:0]   r_ins_idx;

  logic                   r_inv_resp_val;
  logic                   r_inv_resp_hit;
  logic                   r_inv_resp_dirty;
  logic [IDX_WIDTH-1:0]   r_inv_resp_idx;
  logic                   r_lk_resp_val;
  logic                   r_lk_resp_hit;
  logic                   r_lk_resp_dirty;
  logic [IDX_WIDTH-1:0]   r_lk_resp_idx;

  logic                   w_inv_hit;
  logic [IDX_WIDTH-1:0]   w_inv_idx;
  logic                   w_ins_hit;
  logic [IDX_WIDTH-1:0]   w_ins_idx;
  logic                   w_lk_hit;
  logic [IDX_WIDTH-1:0]   w_lk_idx;

  logic                   w_inv_grant;
  logic                   w_ins_grant;
  logic                   w_lk_grant;
  logic                   w_lk_starved;

  // Fully associative compare of each requester's address against the valid entries.
  always_comb begin
    w_inv_hit = 1'b0;
    w_inv_idx = '0;
    w_ins_hit = 1'b0;
    w_ins_idx = '0;
    w_lk_hit  = 1'b0;
    w_lk_idx  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!w_inv_hit && r_valid[i] && (r_tag[i] == i_inv_addr)) begin
        w_inv_hit = 1'b1;
        w_inv_idx = IDX_WIDTH'(i);
      end
      if (!w_ins_hit && r_valid[i] && (r_tag[i] == i_ins_addr)) begin
        w_ins_hit = 1'b1;
        w_ins_idx = IDX_WIDTH'(i);
      end
      if (!w_lk_hit && r_valid[i] && (r_tag[i] == i_lk_addr)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A starved lookup jumps ahead of invalidations; otherwise inv > ins > lk.
  always_comb begin
    w_next_state = r_state;
    w_inv_grant  = 1'b0;
    w_ins_grant  = 1'b0;
    w_lk_grant   = 1'b0;
    w_lk_starved = (r_starve >= STARVE_MAX);
    if (rst_n && (r_state == S_IDLE)) begin
      if (i_lk_val && w_lk_starved) begin
        w_lk_grant = 1'b1;
      end else if (i_inv_val) begin
        w_inv_grant = 1'b1;
      end else if (i_ins_val) begin
        w_ins_grant = 1'b1;
      end else if (i_lk_val) begin
        w_lk_grant = 1'b1;
      end
    end
    case (r_state)
      S_IDLE: begin
        if (w_ins_grant) begin
          if (!w_ins_hit && r_valid[r_ptr] && r_dirty[r_ptr]) begin
            w_next_state = S_WB;
          end else begin
            w_next_state = S_INS_WR;
          end
        end
      end
      S_WB: begin
        if (i_wb_rdy) begin
          w_next_state = S_INS_WR;
        end
      end
      S_INS_WR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Entry state, insert latch, responses and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_tag[i] <= '0;
      end
      r_valid          <= '0;
      r_dirty          <= '0;
      r_ptr            <= '0;
      r_starve         <= '0;
      r_ins_addr       <= '0;
      r_ins_dirty      <= 1'b0;
      r_ins_dup        <= 1'b0;
      r_ins_idx        <= '0;
      r_inv_resp_val   <= 1'b0;
      r_inv_resp_hit   <= 1'b0;
      r_inv_resp_dirty <= 1'b0;
      r_inv_resp_idx   <= '0;
      r_lk_resp_val    <= 1'b0;
      r_lk_resp_hit    <= 1'b0;
      r_lk_resp_dirty  <= 1'b0;
      r_lk_resp_idx    <= '0;
    end else begin
      r_inv_resp_val   <= w_inv_grant;
      r_inv_resp_hit   <= w_inv_grant & w_inv_hit;
      r_inv_resp_dirty <= w_inv_grant & w_inv_hit & r_dirty[w_inv_idx];
      r_inv_resp_idx   <= (w_inv_grant && w_inv_hit) ? w_inv_idx : '0;
      r_lk_resp_val    <= w_lk_grant;
      r_lk_resp_hit    <= w_lk_grant & w_lk_hit;
      r_lk_resp_dirty  <= w_lk_grant & w_lk_hit & r_dirty[w_lk_idx];
      r_lk_resp_idx    <= (w_lk_grant && w_lk_hit) ? w_lk_idx : '0;

      if (w_inv_grant && w_inv_hit) begin
        r_valid[w_inv_idx] <= 1'b0;
        r_dirty[w_inv_idx] <= 1'b0;
      end
      if (w_lk_grant && w_lk_hit) begin
        r_valid[w_lk_idx] <= 1'b0;
        r_dirty[w_lk_idx] <= 1'b0;
      end
      if (w_ins_grant) begin
        r_ins_addr  <= i_ins_addr;
        r_ins_dirty <= i_ins_dirty;
        r_ins_dup   <= w_ins_hit;
        r_ins_idx   <= w_ins_hit ? w_ins_idx : r_ptr;
      end
      if ((r_state == S_WB) && i_wb_rdy) begin
        r_valid[r_ins_idx] <= 1'b0;
        r_dirty[r_ins_idx] <= 1'b0;
      end
      if (r_state == S_INS_WR) begin
        r_tag[r_ins_idx]   <= r_ins_addr;
        r_valid[r_ins_idx] <= 1'b1;
        r_dirty[r_ins_idx] <= r_ins_dirty;
        if (!r_ins_dup) begin
          r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
        end
      end

      if (i_lk_val && !w_lk_grant) begin
        r_starve <= (r_starve == STARVE_MAX) ? r_starve : r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end

  assign o_inv_rdy        = w_inv_grant;
  assign o_ins_rdy        = w_ins_grant;
  assign o_lk_rdy         = w_lk_grant;
  assign o_inv_resp_val   = r_inv_resp_val;
  assign o_inv_resp_hit   = r_inv_resp_hit;
  assign o_inv_resp_dirty = r_inv_resp_dirty;
  assign o_inv_resp_idx   = r_inv_resp_idx;
  assign o_lk_resp_val    = r_lk_resp_val;
  assign o_lk_resp_hit    = r_lk_resp_hit;
  assign o_lk_resp_dirty  = r_lk_resp_dirty;
  assign o_lk_resp_idx    = r_lk_resp_idx;
  assign o_wb_val         = (r_state == S_WB);
  assign o_wb_idx         = o_wb_val ? r_ins_idx : '0;
  assign o_wb_addr        = o_wb_val ? r_tag[r_ins_idx] : '0;
  assign o_arr_we         = (r_state == S_INS_WR);
  assign o_arr_widx       = o_arr_we ? r_ins_idx : '0;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed bench for victim_cache_ctrl: arbitration, FIFO replacement, writeback stall and reset abort.
// Expected values are hand-derived from the entry/pointer history of each step.
`timescale 1ns/1ps

module tb_victim_cache_ctrl;

  localparam int AW = 36;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          invVal, insVal, insDirty, lkVal, wbRdy;
  logic [AW-1:0] invAddr, insAddr, lkAddr;
  logic          invRdy, insRdy, lkRdy;
  logic          invRespVal, invRespHit, invRespDirty;
  logic [IW-1:0] invRespIdx;
  logic          lkRespVal, lkRespHit, lkRespDirty;
  logic [IW-1:0] lkRespIdx;
  logic          wbVal, arrWe;
  logic [IW-1:0] wbIdx, arrWidx;
  logic [AW-1:0] wbAddr;

  int compared = 0;
  int mismatched = 0;

  victim_cache_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_inv_val        (invVal),
    .i_inv_addr       (invAddr),
    .o_inv_rdy        (invRdy),
    .o_inv_resp_val   (invRespVal),
    .o_inv_resp_hit   (invRespHit),
    .o_inv_resp_dirty (invRespDirty),
    .o_inv_resp_idx   (invRespIdx),
    .i_ins_val        (insVal),
    .i_ins_addr       (insAddr),
    .i_ins_dirty      (insDirty),
    .o_ins_rdy        (insRdy),
    .i_lk_val         (lkVal),
    .i_lk_addr        (lkAddr),
    .o_lk_rdy         (lkRdy),
    .o_lk_resp_val    (lkRespVal),
    .o_lk_resp_hit    (lkRespHit),
    .o_lk_resp_dirty  (lkRespDirty),
    .o_lk_resp_idx    (lkRespIdx),
    .o_wb_val         (wbVal),
    .o_wb_idx         (wbIdx),
    .o_wb_addr        (wbAddr),
    .i_wb_rdy         (wbRdy),
    .o_arr_we         (arrWe),
    .o_arr_widx       (arrWidx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [AW-1:0] ia, input logic nv,
                               input logic [AW-1:0] na, input logic nd, input logic lv,
                               input logic [AW-1:0] la, input logic wr);
    invVal   = iv;
    invAddr  = ia;
    insVal   = nv;
    insAddr  = na;
    insDirty = nd;
    lkVal    = lv;
    lkAddr   = la;
    wbRdy    = wr;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyIdle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic doLookup(input string tag, input logic [AW-1:0] addr, input logic eHit,
                          input logic eDirty, input logic [IW-1:0] eIdx);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, addr, 1'b0);
    #1;
    checkOutput({tag, " lk_rdy"}, lkRdy, 1);
    cycle();
    applyIdle();
    #1;
    checkOutput({tag, " lk_resp_val"}, lkRespVal, 1);
    checkOutput({tag, " lk_resp_hit"}, lkRespHit, eHit);
    checkOutput({tag, " lk_resp_dirty"}, lkRespDirty, eDirty);
    checkOutput({tag, " lk_resp_idx"}, lkRespIdx, eIdx);
  endtask

  task automatic doInv(input string tag, input logic [AW-1:0] addr, input logic eHit,
                       input logic eDirty, input logic [IW-1:0] eIdx);
    applyStimulus(1'b1, addr, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput({tag, " inv_rdy"}, invRdy, 1);
    cycle();
    applyIdle();
    #1;
    checkOutput({tag, " inv_resp_val"}, invRespVal, 1);
    checkOutput({tag, " inv_resp_hit"}, invRespHit, eHit);
    checkOutput({tag, " inv_resp_dirty"}, invRespDirty, eDirty);
    checkOutput({tag, " inv_resp_idx"}, invRespIdx, eIdx);
  endtask

  // Insert whose target slot needs no writeback: grant, one INS_WR cycle, back to IDLE.
  task automatic doInsert(input string tag, input logic [AW-1:0] addr, input logic dirty,
                          input logic [IW-1:0] eIdx);
    applyStimulus(1'b0, '0, 1'b1, addr, dirty, 1'b0, '0, 1'b0);
    #1;
    checkOutput({tag, " ins_rdy"}, insRdy, 1);
    cycle();
    applyIdle();
    #1;
    checkOutput({tag, " arr_we"}, arrWe, 1);
    checkOutput({tag, " arr_widx"}, arrWidx, eIdx);
    cycle();
    #1;
    checkOutput({tag, " arr_we low"}, arrWe, 0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with every request raised: nothing may be granted or reported.
    applyStimulus(1'b1, 36'h1, 1'b1, 36'h2, 1'b0, 1'b1, 36'h3, 1'b1);
    rst_n = 1'b0;
    cycle();
    cycle();
    #1;
    checkOutput("reset inv_rdy", invRdy, 0);
    checkOutput("reset ins_rdy", insRdy, 0);
    checkOutput("reset lk_rdy", lkRdy, 0);
    checkOutput("reset inv_resp_val", invRespVal, 0);
    checkOutput("reset lk_resp_val", lkRespVal, 0);
    checkOutput("reset wb_val", wbVal, 0);
    checkOutput("reset arr_we", arrWe, 0);
    checkOutput("reset arr_widx", arrWidx, 0);
    checkOutput("reset wb_addr", wbAddr, 0);
    rst_n = 1'b1;
    applyIdle();

    // Lookup into an empty cache, and the response is a single-cycle pulse.
    doLookup("miss 0x100", 36'h100, 1'b0, 1'b0, 4'd0);
    cycle();
    #1;
    checkOutput("lk pulse width", lkRespVal, 0);

    // Clean insert lands at slot 0; lookup hit migrates it out.
    doInsert("ins A0", 36'hA0, 1'b0, 4'd0);
    doLookup("lk A0", 36'hA0, 1'b1, 1'b0, 4'd0);
    doLookup("lk A0 again", 36'hA0, 1'b0, 1'b0, 4'd0);

    // Fill all 16 slots (slot 0 dirty), then the 17th insert wraps and writes back slot 0.
    doReset();
    for (int i = 0; i < 16; i++) begin
      doInsert($sformatf("fill %0d", i), AW'(i), (i == 0), IW'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 36'h10, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("ins 0x10 rdy", insRdy, 1);
    cycle();
    applyStimulus(1'b1, 36'h5, 1'b0, '0, 1'b0, 1'b1, 36'h5, 1'b0);
    #1;
    checkOutput("wb val", wbVal, 1);
    checkOutput("wb idx", wbIdx, 0);
    checkOutput("wb addr", wbAddr, 36'h0);
    checkOutput("wb inv blocked", invRdy, 0);
    checkOutput("wb lk blocked", lkRdy, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      #1;
      checkOutput($sformatf("stall%0d wb_val", k), wbVal, 1);
      checkOutput($sformatf("stall%0d wb_idx", k), wbIdx, 0);
      checkOutput($sformatf("stall%0d wb_addr", k), wbAddr, 36'h0);
      checkOutput($sformatf("stall%0d inv_rdy", k), invRdy, 0);
      checkOutput($sformatf("stall%0d lk_rdy", k), lkRdy, 0);
      checkOutput($sformatf("stall%0d arr_we", k), arrWe, 0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("wb held until rdy", wbVal, 1);
    cycle();
    applyIdle();
    #1;
    checkOutput("after wb arr_we", arrWe, 1);
    checkOutput("after wb arr_widx", arrWidx, 0);
    checkOutput("after wb wb_val", wbVal, 0);
    cycle();
    doLookup("lk 0x10", 36'h10, 1'b1, 1'b0, 4'd0);
    doLookup("lk 0x00 evicted", 36'h0, 1'b0, 1'b0, 4'd0);
    doLookup("lk 0x05", 36'h5, 1'b1, 1'b0, 4'd5);

    // All three requesting: inv, then ins, then a starved lookup beats inv.
    applyStimulus(1'b1, 36'h3, 1'b1, 36'h20, 1'b0, 1'b1, 36'h7, 1'b0);
    #1;
    checkOutput("prio inv first", invRdy, 1);
    checkOutput("prio ins waits", insRdy, 0);
    checkOutput("prio lk waits", lkRdy, 0);
    cycle();
    applyStimulus(1'b0, '0, 1'b1, 36'h20, 1'b0, 1'b1, 36'h7, 1'b0);
    #1;
    checkOutput("inv 0x03 resp_val", invRespVal, 1);
    checkOutput("inv 0x03 hit", invRespHit, 1);
    checkOutput("inv 0x03 idx", invRespIdx, 3);
    checkOutput("inv 0x03 dirty", invRespDirty, 0);
    checkOutput("prio ins second", insRdy, 1);
    checkOutput("prio lk still waits", lkRdy, 0);
    cycle();
    applyStimulus(1'b1, 36'h4, 1'b0, '0, 1'b0, 1'b1, 36'h7, 1'b0);
    #1;
    checkOutput("ins 0x20 arr_we", arrWe, 1);
    checkOutput("ins 0x20 arr_widx", arrWidx, 1);
    checkOutput("ins_wr blocks inv", invRdy, 0);
    checkOutput("ins_wr blocks lk", lkRdy, 0);
    cycle();
    #1;
    checkOutput("starve3 inv wins", invRdy, 1);
    checkOutput("starve3 lk denied", lkRdy, 0);
    cycle();
    #1;
    checkOutput("starve4 lk wins", lkRdy, 1);
    checkOutput("starve4 inv denied", invRdy, 0);
    checkOutput("inv 0x04 resp_val", invRespVal, 1);
    checkOutput("inv 0x04 idx", invRespIdx, 4);
    cycle();
    applyIdle();
    #1;
    checkOutput("starved lk resp_val", lkRespVal, 1);
    checkOutput("starved lk hit", lkRespHit, 1);
    checkOutput("starved lk idx", lkRespIdx, 7);
    checkOutput("inv pulse width", invRespVal, 0);
    doInv("inv miss 0x03", 36'h3, 1'b0, 1'b0, 4'd0);

    // Duplicate insert reuses its slot and leaves the pointer alone.
    doInsert("ins B0", 36'hB0, 1'b0, 4'd2);
    doInsert("ins B0 dup", 36'hB0, 1'b1, 4'd2);
    doLookup("lk B0", 36'hB0, 1'b1, 1'b1, 4'd2);
    doInsert("ins C0", 36'hC0, 1'b0, 4'd3);
    doLookup("lk 0x02 replaced", 36'h2, 1'b0, 1'b0, 4'd0);

    // Reset while a writeback is pending abandons it and forgets every entry.
    doReset();
    for (int i = 0; i < 16; i++) begin
      doInsert($sformatf("refill %0d", i), AW'(36'h200 + i), (i == 0), IW'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 36'h300, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("ins 0x300 rdy", insRdy, 1);
    cycle();
    applyIdle();
    #1;
    checkOutput("pre-reset wb_val", wbVal, 1);
    checkOutput("pre-reset wb_addr", wbAddr, 36'h200);
    rst_n = 1'b0;
    cycle();
    #1;
    checkOutput("reset mid-wb wb_val", wbVal, 0);
    checkOutput("reset mid-wb arr_we", arrWe, 0);
    rst_n = 1'b1;
    cycle();
    #1;
    checkOutput("post-reset wb_val", wbVal, 0);
    checkOutput("post-reset arr_we", arrWe, 0);
    doLookup("post-reset 0x200", 36'h200, 1'b0, 1'b0, 4'd0);
    doLookup("post-reset 0x20F", 36'h20F, 1'b0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
